// File: rtl/mesi_coherence_monitor_if.sv
// Monitored coherence bus: per-CPU cache line states plus main-bus command/ack.
// master drives the bus (cache/CPU models), slave observes it (the monitor).
interface mesi_coherence_monitor_if #(
    parameter int CPU_COUNT  = 4,
    parameter int LINE_COUNT = 10,
    parameter int STATE_W    = 4,
    parameter int CMD_W      = 3
);
    logic [CPU_COUNT*LINE_COUNT*STATE_W-1:0] cache_state;
    logic [CPU_COUNT*CMD_W-1:0]              mbus_cmd_array;
    logic [CPU_COUNT-1:0]                    mbus_ack_array;

    modport master (output cache_state, output mbus_cmd_array, output mbus_ack_array);
    modport slave  (input  cache_state, input  mbus_cmd_array, input  mbus_ack_array);
endinterface

// File: rtl/mesi_coherence_monitor.sv
// MESI checker: encoding, multi-owner, owner+sharer, transition and per-CPU ack-timeout checks.
// Errors on sample cycle N are reported (pulse/count/first-error capture) at cycle N+1; never stalls the bus.
module mesi_coherence_monitor #(
    parameter int                 CPU_COUNT  = 4,
    parameter int                 LINE_COUNT = 10,
    parameter int                 STATE_W    = 4,
    parameter logic [STATE_W-1:0] ST_M       = STATE_W'(4'b1001),
    parameter logic [STATE_W-1:0] ST_E       = STATE_W'(4'b0101),
    parameter logic [STATE_W-1:0] ST_S       = STATE_W'(4'b0011),
    parameter logic [STATE_W-1:0] ST_I       = STATE_W'(4'b0000),
    parameter int                 CMD_W      = 3,
    parameter int                 TIMEOUT    = 64,
    parameter int                 CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          chk_en,
    input  logic                          err_clr,
    mesi_coherence_monitor_if.slave       bus,
    output logic                          err_pulse,
    output logic [2:0]                    err_code,
    output logic [$clog2(CPU_COUNT)-1:0]  err_cpu,
    output logic [$clog2(LINE_COUNT)-1:0] err_line,
    output logic                          err_sticky,
    output logic [CNT_W-1:0]              err_count
);
    localparam int CPU_W  = $clog2(CPU_COUNT);
    localparam int LINE_W = $clog2(LINE_COUNT);
    localparam int WD_W   = $clog2(TIMEOUT);
    localparam int ALL_W  = CPU_COUNT*LINE_COUNT*STATE_W;

    localparam logic [1:0] WD_IDLE  = 2'd0;
    localparam logic [1:0] WD_WAIT  = 2'd1;
    localparam logic [1:0] WD_STUCK = 2'd2;

    logic [ALL_W-1:0]                  shadow_q, shadow_d;
    logic                              prev_valid_q, prev_valid_d;
    logic [CPU_COUNT-1:0][1:0]         wd_st_q, wd_st_d;
    logic [CPU_COUNT-1:0][WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic                              err_pulse_q, err_pulse_d;
    logic [2:0]                        err_code_q, err_code_d;
    logic [CPU_W-1:0]                  err_cpu_q, err_cpu_d;
    logic [LINE_W-1:0]                 err_line_q, err_line_d;
    logic                              err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]                  err_count_q, err_count_d;

    logic [CPU_COUNT-1:0]                         cmd_vld;
    logic [CPU_COUNT-1:0]                         tmo;
    logic [LINE_COUNT-1:0][CPU_COUNT-1:0]         own_m, shr_m;
    logic [3:0][LINE_COUNT-1:0][CPU_COUNT-1:0]    flg;
    logic                                         hit;
    logic [2:0]                                   hit_code;
    logic [CPU_W-1:0]                             hit_cpu;
    logic [LINE_W-1:0]                            hit_line;
    logic                                         rpt;

    for (genvar g = 0; g < CPU_COUNT; g++) begin : g_cmd
        assign cmd_vld[g] = |bus.mbus_cmd_array[g*CMD_W +: CMD_W];
    end

    always_comb begin
        wd_st_d  = wd_st_q;
        wd_cnt_d = wd_cnt_q;
        tmo      = '0;
        for (int c = 0; c < CPU_COUNT; c++) begin
            case (wd_st_q[c])
                WD_IDLE: if (cmd_vld[c] && !bus.mbus_ack_array[c]) begin
                    wd_st_d[c]  = WD_WAIT;
                    wd_cnt_d[c] = WD_W'(1);
                end
                WD_WAIT: if (bus.mbus_ack_array[c]) begin
                    wd_st_d[c] = WD_IDLE;
                end else if (wd_cnt_q[c] == WD_W'(TIMEOUT-1)) begin
                    // This cycle would make the count reach TIMEOUT.
                    tmo[c]     = 1'b1;
                    wd_st_d[c] = WD_STUCK;
                end else begin
                    wd_cnt_d[c] = wd_cnt_q[c] + WD_W'(1);
                end
                WD_STUCK: if (!cmd_vld[c] || bus.mbus_ack_array[c]) wd_st_d[c] = WD_IDLE;
                default: wd_st_d[c] = WD_IDLE;
            endcase
        end
    end

    always_comb begin
        own_m = '0;
        shr_m = '0;
        flg   = '0;
        for (int l = 0; l < LINE_COUNT; l++) begin
            for (int c = 0; c < CPU_COUNT; c++) begin
                logic [STATE_W-1:0] st, pv;
                st = bus.cache_state[(c*LINE_COUNT+l)*STATE_W +: STATE_W];
                pv = shadow_q[(c*LINE_COUNT+l)*STATE_W +: STATE_W];
                own_m[l][c]  = (st == ST_M) || (st == ST_E);
                shr_m[l][c]  = (st == ST_S);
                flg[0][l][c] = !((st == ST_M) || (st == ST_E) || (st == ST_S) || (st == ST_I));
                flg[3][l][c] = prev_valid_q && (st == ST_E) && ((pv == ST_M) || (pv == ST_S));
            end
            if ($countones(own_m[l]) > 1) flg[1][l] = own_m[l];
            // Owner+sharer blames every CPU holding a valid copy of the line.
            if (($countones(own_m[l]) == 1) && (|shr_m[l])) flg[2][l] = own_m[l] | shr_m[l];
        end
    end

    always_comb begin
        hit      = 1'b0;
        hit_code = 3'd0;
        hit_cpu  = '0;
        hit_line = '0;
        for (int c = CPU_COUNT-1; c >= 0; c--) begin
            if (tmo[c]) begin
                hit      = 1'b1;
                hit_code = 3'd5;
                hit_cpu  = CPU_W'(c);
                hit_line = '0;
            end
        end
        // Scan in reverse priority so the last match is the lowest code, line, cpu.
        for (int k = 3; k >= 0; k--) begin
            for (int l = LINE_COUNT-1; l >= 0; l--) begin
                for (int c = CPU_COUNT-1; c >= 0; c--) begin
                    if (flg[k][l][c]) begin
                        hit      = 1'b1;
                        hit_code = 3'(k+1);
                        hit_cpu  = CPU_W'(c);
                        hit_line = LINE_W'(l);
                    end
                end
            end
        end
    end

    always_comb begin
        shadow_d     = bus.cache_state;
        prev_valid_d = 1'b1;
        rpt          = chk_en && hit;
        err_pulse_d  = rpt;
        err_count_d  = err_count_q;
        err_sticky_d = err_sticky_q;
        err_code_d   = err_code_q;
        err_cpu_d    = err_cpu_q;
        err_line_d   = err_line_q;
        if (rpt && (err_count_q != {CNT_W{1'b1}})) err_count_d = err_count_q + CNT_W'(1);
        if (err_clr) begin
            err_sticky_d = 1'b0;
            err_code_d   = 3'd0;
            err_cpu_d    = '0;
            err_line_d   = '0;
        end
        if (rpt && (!err_sticky_q || err_clr)) begin
            err_sticky_d = 1'b1;
            err_code_d   = hit_code;
            err_cpu_d    = hit_cpu;
            err_line_d   = hit_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q     <= {(CPU_COUNT*LINE_COUNT){ST_I}};
            prev_valid_q <= 1'b0;
            wd_st_q      <= {CPU_COUNT{WD_IDLE}};
            wd_cnt_q     <= '0;
            err_pulse_q  <= 1'b0;
            err_code_q   <= 3'd0;
            err_cpu_q    <= '0;
            err_line_q   <= '0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            shadow_q     <= shadow_d;
            prev_valid_q <= prev_valid_d;
            wd_st_q      <= wd_st_d;
            wd_cnt_q     <= wd_cnt_d;
            err_pulse_q  <= err_pulse_d;
            err_code_q   <= err_code_d;
            err_cpu_q    <= err_cpu_d;
            err_line_q   <= err_line_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign err_pulse  = err_pulse_q;
    assign err_code   = err_code_q;
    assign err_cpu    = err_cpu_q;
    assign err_line   = err_line_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
endmodule
